prot_len_prepend: RTL and testbench

- Store-and-forward stage directly upstream of the UDP/IP TX protocol engine.
- Buffers one complete 36-bit frame (sof/eof/occ framing) and counts its payload bytes.
- Emits a control word {port_sel, use_hdr, length} followed by the buffered payload. This is the leading word the protocol engine consumes to build ETH/IP/UDP headers.
- Also drops oversize frames, since a length word cannot be issued before the frame ends.

---
 rtl/prot_len_prepend.sv | 224 ++++++++++++++++++++++
 tb/tb_prot_len_prepend.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/prot_len_prepend.sv
`default_nettype none
// ============================================================================
// Module      : prot_len_prepend
// Description : Store-and-forward stage ahead of the UDP/IP TX engine.
//               Buffers one complete 36-bit frame, counts its payload bytes,
//               then emits a control word {port_sel, use_hdr, length}
//               followed by the buffered payload. Oversize frames are
//               dropped because their length cannot be known up front.
// Revision    : 1.0 - initial release
// ============================================================================
module prot_len_prepend #(
  parameter int BASE   = 0,
  parameter int AWIDTH = 9
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clear,
  input  logic        set_stb,
  input  logic [7:0]  set_addr,
  input  logic [31:0] set_data,
  input  logic [35:0] datain,
  input  logic        src_rdy_i,
  output logic        dst_rdy_o,
  output logic [35:0] dataout,
  output logic        src_rdy_o,
  input  logic        dst_rdy_i,
  output logic [15:0] drop_count
);

  localparam int          c_depth     = 1 << AWIDTH;
  localparam logic [7:0]  c_base_addr = 8'(BASE);

  localparam logic [1:0] c_st_fill  = 2'd0;
  localparam logic [1:0] c_st_drop  = 2'd1;
  localparam logic [1:0] c_st_hdr   = 2'd2;
  localparam logic [1:0] c_st_drain = 2'd3;

  logic [1:0]        r_state;
  logic [1:0]        w_next_state;

  logic [35:0]       r_mem [0:c_depth-1];
  logic [35:0]       r_rd_data;
  logic [AWIDTH-1:0] r_wcnt;
  logic [AWIDTH-1:0] r_last;
  logic [AWIDTH-1:0] r_rptr;
  logic [15:0]       r_len;
  logic [2:0]        r_port_sel;
  logic              r_use_hdr;
  logic [2:0]        r_hdr_port_sel;
  logic              r_hdr_use_hdr;
  logic [15:0]       r_drop_count;

  logic              w_sof;
  logic              w_eof;
  logic [1:0]        w_occ;
  logic              w_in_xfer;
  logic              w_restart;
  logic              w_discard;
  logic              w_full;
  logic [AWIDTH-1:0] w_idx;
  logic [AWIDTH:0]   w_words;
  logic [15:0]       w_bytes;
  logic [2:0]        w_trim;
  logic [15:0]       w_len;
  logic              w_fill_store;
  logic              w_fill_eof;
  logic              w_drop_evt;
  logic              w_out_xfer;
  logic              w_rd_advance;
  logic [AWIDTH-1:0] w_rd_addr;
  logic              w_unused;

  assign w_unused = &{1'b0, set_data[31:4]};

  assign w_sof     = datain[32];
  assign w_eof     = datain[33];
  assign w_occ     = datain[35:34];
  assign w_in_xfer = src_rdy_i & dst_rdy_o;

  // A new sof inside a partially filled frame restarts at address 0;
  // a stray non-sof word with nothing buffered is ignored.
  assign w_restart = w_sof & (r_wcnt != '0);
  assign w_discard = ~w_sof & (r_wcnt == '0);
  assign w_idx     = w_restart ? '0 : r_wcnt;
  assign w_full    = (w_idx == '1);

  // Byte length: four bytes per word, trimmed by the last word's occupancy.
  assign w_words = {1'b0, w_idx} + 1'b1;
  assign w_bytes = 16'({w_words, 2'b00});
  assign w_trim  = (w_occ == 2'd0) ? 3'd0 : (3'd4 - {1'b0, w_occ});
  assign w_len   = w_bytes - {13'd0, w_trim};

  assign w_fill_store = (r_state == c_st_fill) & w_in_xfer & ~w_discard;
  assign w_fill_eof   = w_fill_store & w_eof;
  assign w_drop_evt   = (r_state == c_st_fill) & w_in_xfer &
                        (w_restart | (~w_discard & ~w_eof & w_full));

  assign w_out_xfer   = src_rdy_o & dst_rdy_i;
  assign w_rd_advance = (r_state == c_st_drain) & dst_rdy_i & (r_rptr != r_last);
  assign w_rd_addr    = w_rd_advance ? (r_rptr + 1'b1) : r_rptr;

  assign drop_count = r_drop_count;

  // State register.
  always_ff @(posedge clk) begin
    if (!reset_n || clear)
      r_state <= c_st_fill;
    else
      r_state <= w_next_state;
  end

  // Next-state decode.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_st_fill: begin
        if (w_fill_store) begin
          if (w_eof)
            w_next_state = c_st_hdr;
          else if (w_full)
            w_next_state = c_st_drop;
        end
      end
      c_st_drop: begin
        if (w_in_xfer && w_eof)
          w_next_state = c_st_fill;
      end
      c_st_hdr: begin
        if (dst_rdy_i)
          w_next_state = c_st_drain;
      end
      default: begin
        if (dst_rdy_i && (r_rptr == r_last))
          w_next_state = c_st_fill;
      end
    endcase
  end

  // Output decode; all outputs derive from registered state only.
  always_comb begin
    dst_rdy_o = 1'b0;
    src_rdy_o = 1'b0;
    dataout   = '0;
    case (r_state)
      c_st_fill: dst_rdy_o = 1'b1;
      c_st_drop: dst_rdy_o = 1'b1;
      c_st_hdr: begin
        src_rdy_o = 1'b1;
        dataout   = {2'b00, 1'b0, 1'b1, 12'h000,
                     r_hdr_port_sel, r_hdr_use_hdr, r_len};
      end
      default: begin
        src_rdy_o = 1'b1;
        dataout   = {r_rd_data[35:33], 1'b0, r_rd_data[31:0]};
      end
    endcase
  end

  // Payload buffer: write during FILL, registered read with look-ahead address.
  always_ff @(posedge clk) begin
    if (w_fill_store)
      r_mem[w_idx] <= datain;
    r_rd_data <= r_mem[w_rd_addr];
  end

  // Fill counter plus frame length / last index captured at eof.
  always_ff @(posedge clk) begin
    if (!reset_n || clear) begin
      r_wcnt <= '0;
      r_last <= '0;
      r_len  <= '0;
    end else if (w_fill_store) begin
      if (w_eof) begin
        r_wcnt <= '0;
        r_last <= w_idx;
        r_len  <= w_len;
      end else if (w_full) begin
        r_wcnt <= '0;
      end else begin
        r_wcnt <= w_idx + 1'b1;
      end
    end
  end

  // Read pointer walks the stored frame as payload words are accepted.
  always_ff @(posedge clk) begin
    if (!reset_n || clear)
      r_rptr <= '0;
    else if ((r_state == c_st_drain) && w_out_xfer)
      r_rptr <= (r_rptr == r_last) ? '0 : (r_rptr + 1'b1);
  end

  // Settings register survives clear; only reset restores the defaults.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_port_sel <= 3'd0;
      r_use_hdr  <= 1'b1;
    end else if (set_stb && (set_addr == c_base_addr)) begin
      r_port_sel <= set_data[2:0];
      r_use_hdr  <= set_data[3];
    end
  end

  // Snapshot settings on entry to HDR so later writes hit the next frame.
  always_ff @(posedge clk) begin
    if (!reset_n || clear) begin
      r_hdr_port_sel <= 3'd0;
      r_hdr_use_hdr  <= 1'b1;
    end else if (w_fill_eof) begin
      r_hdr_port_sel <= r_port_sel;
      r_hdr_use_hdr  <= r_use_hdr;
    end
  end

  // Saturating drop counter, cleared by reset only.
  always_ff @(posedge clk) begin
    if (!reset_n)
      r_drop_count <= '0;
    else if (w_drop_evt && (r_drop_count != 16'hFFFF))
      r_drop_count <= r_drop_count + 16'd1;
  end

endmodule
`default_nettype wire

// File: tb/tb_prot_len_prepend.sv
`default_nettype none
// ============================================================================
// Module      : tb_prot_len_prepend
// Description : Directed self-checking bench for prot_len_prepend.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_prot_len_prepend;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        clear;
  logic        set_stb;
  logic [7:0]  set_addr;
  logic [31:0] set_data;
  logic [35:0] datain;
  logic        src_rdy_i;
  logic        dst_rdy_o;
  logic [35:0] dataout;
  logic        src_rdy_o;
  logic        dst_rdy_i;
  logic [15:0] drop_count;

  int checks = 0;
  int errors = 0;
  logic [35:0] got[$];
  int          gcyc[$];

  always #5 clk = ~clk;

  prot_len_prepend #(.BASE(0), .AWIDTH(4)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .clear      (clear),
    .set_stb    (set_stb),
    .set_addr   (set_addr),
    .set_data   (set_data),
    .datain     (datain),
    .src_rdy_i  (src_rdy_i),
    .dst_rdy_o  (dst_rdy_o),
    .dataout    (dataout),
    .src_rdy_o  (src_rdy_o),
    .dst_rdy_i  (dst_rdy_i),
    .drop_count (drop_count)
  );

  function automatic logic [35:0] pay(input int n, input logic [1:0] occ_last,
                                      input logic [31:0] base, input int k);
    logic [1:0] occ;
    occ = (k == n - 1) ? occ_last : 2'd0;
    return {occ, (k == n - 1) ? 1'b1 : 1'b0, 1'b0, base + 32'(k)};
  endfunction

  task automatic send_word(input bit sof, input bit eof, input logic [1:0] occ,
                           input logic [31:0] d);
    int t = 0;
    datain    = {occ, eof, sof, d};
    src_rdy_i = 1'b1;
    @(negedge clk);
    while (!dst_rdy_o && t < 100) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (dst_rdy_o !== 1'b1 || src_rdy_o !== 1'b0) begin
      errors++;
      $display("FAIL input_ready: dst_rdy_o=%b src_rdy_o=%b required 1/0", dst_rdy_o, src_rdy_o);
    end
    @(posedge clk); #1;
    src_rdy_i = 1'b0;
  endtask

  task automatic send_frame(input int n, input logic [1:0] occ_last, input logic [31:0] base);
    for (int i = 0; i < n; i++)
      send_word(i == 0, i == n - 1, (i == n - 1) ? occ_last : 2'd0, base + 32'(i));
  endtask

  task automatic collect(input int n, input bit toggle);
    int cyc = 0;
    got.delete();
    gcyc.delete();
    dst_rdy_i = 1'b1;
    while (got.size() < n && cyc < 2000) begin
      @(negedge clk);
      if (src_rdy_o && dst_rdy_i) begin
        got.push_back(dataout);
        gcyc.push_back(cyc);
      end
      @(posedge clk); #1;
      cyc++;
      if (toggle) dst_rdy_i = ~dst_rdy_i;
    end
    dst_rdy_i = 1'b0;
    checks++;
    if (got.size() != n) begin
      errors++;
      $display("FAIL collect_count: got %0d words required %0d", got.size(), n);
    end
  endtask

  task automatic set_write(input logic [7:0] a, input logic [31:0] d);
    set_addr = a;
    set_data = d;
    set_stb  = 1'b1;
    @(posedge clk); #1;
    set_stb  = 1'b0;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    checks++;
    if (src_rdy_o !== 1'b0) begin errors++; $display("FAIL reset_src_rdy: got %b required 0", src_rdy_o); end
    checks++;
    if (dst_rdy_o !== 1'b1) begin errors++; $display("FAIL reset_dst_rdy: got %b required 1", dst_rdy_o); end
    checks++;
    if (drop_count !== 16'd0) begin errors++; $display("FAIL reset_drop: got %h required 0000", drop_count); end
  endtask

  task automatic test_basic;
    send_frame(3, 2'd2, 32'hA000_0000);
    collect(4, 1'b0);
    checks++;
    if (got[0] !== 36'h1_0001_000A) begin errors++; $display("FAIL basic_hdr: got %h required %h", got[0], 36'h1_0001_000A); end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (got[k+1] !== pay(3, 2'd2, 32'hA000_0000, k)) begin
        errors++; $display("FAIL basic_pay%0d: got %h required %h", k, got[k+1], pay(3, 2'd2, 32'hA000_0000, k));
      end
    end
    checks++;
    if (gcyc[3] - gcyc[0] != 3) begin errors++; $display("FAIL basic_no_bubble: span %0d required 3", gcyc[3] - gcyc[0]); end
  endtask

  task automatic test_settings;
    set_write(8'h00, 32'h5);
    set_write(8'h01, 32'h0);
    send_frame(1, 2'd0, 32'h1234_5678);
    collect(2, 1'b0);
    checks++;
    if (got[0] !== 36'h1_000A_0004) begin errors++; $display("FAIL settings_hdr: got %h required %h", got[0], 36'h1_000A_0004); end
    checks++;
    if (got[1] !== 36'h2_1234_5678) begin errors++; $display("FAIL settings_pay: got %h required %h", got[1], 36'h2_1234_5678); end
    set_write(8'h00, 32'h8);
  endtask

  task automatic test_restart;
    send_word(1'b0, 1'b1, 2'd0, 32'hDEAD_0000);
    send_word(1'b1, 1'b0, 2'd0, 32'hB000_0000);
    send_word(1'b0, 1'b0, 2'd0, 32'hB000_0001);
    send_frame(3, 2'd1, 32'hC000_0000);
    collect(4, 1'b0);
    checks++;
    if (got[0] !== 36'h1_0001_0009) begin errors++; $display("FAIL restart_hdr: got %h required %h", got[0], 36'h1_0001_0009); end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (got[k+1] !== pay(3, 2'd1, 32'hC000_0000, k)) begin
        errors++; $display("FAIL restart_pay%0d: got %h required %h", k, got[k+1], pay(3, 2'd1, 32'hC000_0000, k));
      end
    end
    checks++;
    if (drop_count !== 16'd1) begin errors++; $display("FAIL restart_drop: got %0d required 1", drop_count); end
  endtask

  task automatic test_oversize;
    bit seen = 1'b0;
    send_frame(16, 2'd0, 32'h6000_0000);
    collect(17, 1'b0);
    checks++;
    if (got[0] !== 36'h1_0001_0040) begin errors++; $display("FAIL full_hdr: got %h required %h", got[0], 36'h1_0001_0040); end
    checks++;
    if (got[16] !== pay(16, 2'd0, 32'h6000_0000, 15)) begin
      errors++; $display("FAIL full_last: got %h required %h", got[16], pay(16, 2'd0, 32'h6000_0000, 15));
    end
    send_frame(19, 2'd0, 32'hE000_0000);
    dst_rdy_i = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (src_rdy_o !== 1'b0) seen = 1'b1;
    end
    @(posedge clk); #1;
    dst_rdy_i = 1'b0;
    checks++;
    if (seen) begin errors++; $display("FAIL oversize_idle: output valid seen, required none"); end
    checks++;
    if (drop_count !== 16'd2) begin errors++; $display("FAIL oversize_drop: got %0d required 2", drop_count); end
    send_frame(2, 2'd0, 32'hF000_0000);
    collect(3, 1'b0);
    checks++;
    if (got[0] !== 36'h1_0001_0008) begin errors++; $display("FAIL after_drop_hdr: got %h required %h", got[0], 36'h1_0001_0008); end
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (got[k+1] !== pay(2, 2'd0, 32'hF000_0000, k)) begin
        errors++; $display("FAIL after_drop_pay%0d: got %h required %h", k, got[k+1], pay(2, 2'd0, 32'hF000_0000, k));
      end
    end
  endtask

  task automatic test_back_to_back;
    send_frame(5, 2'd3, 32'h5000_0000);
    collect(6, 1'b1);
    checks++;
    if (got[0] !== 36'h1_0001_0013) begin errors++; $display("FAIL bp_hdr: got %h required %h", got[0], 36'h1_0001_0013); end
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (got[k+1] !== pay(5, 2'd3, 32'h5000_0000, k)) begin
        errors++; $display("FAIL bp_pay%0d: got %h required %h", k, got[k+1], pay(5, 2'd3, 32'h5000_0000, k));
      end
    end
  endtask

  task automatic test_reset_drain;
    bit seen = 1'b0;
    send_frame(4, 2'd0, 32'h7000_0000);
    collect(2, 1'b0);
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    checks++;
    if (src_rdy_o !== 1'b0) begin errors++; $display("FAIL rst_drain_src: got %b required 0", src_rdy_o); end
    checks++;
    if (dst_rdy_o !== 1'b1) begin errors++; $display("FAIL rst_drain_dst: got %b required 1", dst_rdy_o); end
    checks++;
    if (drop_count !== 16'd0) begin errors++; $display("FAIL rst_drain_drop: got %0d required 0", drop_count); end
    dst_rdy_i = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (src_rdy_o !== 1'b0) seen = 1'b1;
    end
    @(posedge clk); #1;
    dst_rdy_i = 1'b0;
    checks++;
    if (seen) begin errors++; $display("FAIL rst_drain_idle: output valid seen, required none"); end
    send_frame(2, 2'd2, 32'h8000_0000);
    collect(3, 1'b0);
    checks++;
    if (got[0] !== 36'h1_0001_0006) begin errors++; $display("FAIL rst_next_hdr: got %h required %h", got[0], 36'h1_0001_0006); end
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (got[k+1] !== pay(2, 2'd2, 32'h8000_0000, k)) begin
        errors++; $display("FAIL rst_next_pay%0d: got %h required %h", k, got[k+1], pay(2, 2'd2, 32'h8000_0000, k));
      end
    end
  endtask

  initial begin
    reset_n   = 1'b0;
    clear     = 1'b0;
    set_stb   = 1'b0;
    set_addr  = 8'h00;
    set_data  = 32'h0;
    datain    = 36'h0;
    src_rdy_i = 1'b0;
    dst_rdy_i = 1'b0;
    test_reset();
    test_basic();
    test_settings();
    test_restart();
    test_oversize();
    test_back_to_back();
    test_reset_drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
